fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction prefetch queue between the PC/instruction-memory side of the pipeline and the decode pipeline register. It issues sequential fetch requests to a latency-variable instruction memory port and buffers returned instructions with their PCs in an in-order FIFO. It presents them to decode through a valid/ready handshake, where ready is driven from the hazard unit's not-StallD. A branch/jump redirect from execute empties the queue, discards in-flight responses and restarts fetch at the target.

## Interface
- PC_WIDTH, 32, width of program counter and fetch address
- INSTR_WIDTH, 32, instruction width
- DEPTH, 4, queue entries; power of two, >= 2
- MAX_OUTSTANDING, 2, max granted-but-unanswered requests; 1..DEPTH
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk_i  in  1  single clock, all state on rising edge
- rst_i  in  1  asynchronous, active-low reset
- redirect_i  in  1  taken branch/jump in execute (PCSrcE)
- redirect_pc_i  in  PC_WIDTH  redirect target
- mem_req_o  out  1  fetch request
- mem_addr_o  out  PC_WIDTH  fetch address (= fetch_pc)
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  response valid, in request order
- mem_rdata_i  in  INSTR_WIDTH  response instruction
- valid_o  out  1  head entry available to decode
- instr_o  out  INSTR_WIDTH  head instruction; 32'h0000_0013 (NOP) when valid_o=0
- pc_o  out  PC_WIDTH  head PC; 0 when valid_o=0
- pc_plus4_o  out  PC_WIDTH  pc_o + 4 (mod 2^PC_WIDTH); 0 when valid_o=0
- ready_i  in  1  decode accepts head (not StallD)
- count_o  out  $clog2(DEPTH)+1  valid entries in queue

## Operation
- State: fetch_pc; queue of DEPTH {pc, instr} entries with rd/wr pointers and count; in-flight PC FIFO of MAX_OUTSTANDING tags; outstanding counter; drop counter.
- Issue: mem_req_o = rst_i && !redirect_i && outstanding < MAX_OUTSTANDING && (count + outstanding) < DEPTH. Slot reservation guarantees every response has a queue slot.
- Grant (mem_req_o && mem_gnt_i): push fetch_pc into tag FIFO, fetch_pc += 4 (wraps), outstanding++.
- Response (mem_rvalid_i): outstanding--. If drop counter > 0: discard, drop counter--. Otherwise pop tag, write {tag, mem_rdata_i} at tail, count++.
- mem_rvalid_i with outstanding == 0: ignored, no state change.
- Pop: valid_o && ready_i, so rd pointer advances and count--. Simultaneous push and pop leaves count unchanged. Pop on an empty queue is impossible because valid_o=0.
- valid_o = (count != 0) && !redirect_i, i.e. masked combinationally during the redirect cycle.
- Redirect cycle: queue cleared (count=0, pointers reset), tag FIFO cleared, fetch_pc <= {redirect_pc_i[PC_WIDTH-1:2], 2'b00}. The drop counter is loaded with the outstanding value after this cycle's response is accounted; any response in this cycle is discarded. Pop and grant are suppressed. No request is issued in this cycle.
- Back-to-back redirects: the later target wins and in-flight accounting stays correct.
- Drop counter > 0 does not block issue: new responses arrive strictly after the dropped ones.

## Timing
- While rst_i low (asynchronously): fetch_pc=RESET_PC, count=0, outstanding=0, drop=0; mem_req_o=0, mem_addr_o=RESET_PC, valid_o=0, instr_o=NOP, pc_o=0, pc_plus4_o=0, count_o=0.
- mem_req_o is asserted in the first cycle after rst_i deasserts.
- Grant in cycle N, rvalid in cycle N+L (L>=1), so valid_o is high in cycle N+L+1. There is no response bypass.
- Steady state with L=1, MAX_OUTSTANDING>=2 and ready_i=1 sustains one instruction per cycle.
- Redirect in cycle R: mem_req_o=1 with mem_addr_o=target in cycle R+1.
- mem_req_o may deassert without a grant. mem_addr_o is stable while mem_req_o is high and not granted.

## Test plan
- Reset then gnt=1, L=1, ready_i=1: requests 0x0, 0x4, 0x8… each cycle. valid_o rises 2 cycles after first grant with pc_o=0x0 and pc_plus4_o=0x4, then one instruction per cycle in order.
- ready_i=0 with DEPTH=4: count_o saturates at 4 and mem_req_o drops once count+outstanding=4. When ready_i=1, entries 0x0..0xC drain in order and fetch resumes at 0x10.
- Two grants outstanding (L=3), redirect_i with redirect_pc_i=0x103 at the cycle of first rvalid: both responses discarded, next request addr=0x100, first valid_o shows pc_o=0x100.
- Redirect with queue full and ready_i=1 in the same cycle: valid_o=0 that cycle, count_o=0 next cycle, no pop counted.
- mem_gnt_i held low 5 cycles: mem_addr_o stable at the same address, no queue change. A spurious mem_rvalid_i with outstanding=0 causes no state change.
- fetch_pc=0xFFFF_FFFC granted: next mem_addr_o=0x0, and pc_plus4_o for that entry is 0x0.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: redirect input, instruction-memory request/response port and
// the decode-side valid/ready handshake. The master modport is the fetch queue's own view.
interface fetch_queue_if #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                   redirect_i;
  logic [PC_WIDTH-1:0]    redirect_pc_i;
  logic                   mem_req_o;
  logic [PC_WIDTH-1:0]    mem_addr_o;
  logic                   mem_gnt_i;
  logic                   mem_rvalid_i;
  logic [INSTR_WIDTH-1:0] mem_rdata_i;
  logic                   valid_o;
  logic [INSTR_WIDTH-1:0] instr_o;
  logic [PC_WIDTH-1:0]    pc_o;
  logic [PC_WIDTH-1:0]    pc_plus4_o;
  logic                   ready_i;
  logic [CNT_W-1:0]       count_o;

  modport master (
    input  redirect_i, redirect_pc_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, ready_i,
    output mem_req_o, mem_addr_o, valid_o, instr_o, pc_o, pc_plus4_o, count_o
  );

  modport slave (
    output redirect_i, redirect_pc_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, ready_i,
    input  mem_req_o, mem_addr_o, valid_o, instr_o, pc_o, pc_plus4_o, count_o
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential fetch with slot reservation, in-order {pc, instr}
// buffer towards decode, and redirect flush that drops responses still in flight.
module fetch_queue #(
  parameter int                     PC_WIDTH        = 32,
  parameter int                     INSTR_WIDTH     = 32,
  parameter int                     DEPTH           = 4,
  parameter int                     MAX_OUTSTANDING = 2,
  parameter logic [PC_WIDTH-1:0]    RESET_PC        = '0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(32'h0000_0013);

  logic [PC_WIDTH-1:0]    fetchPc;
  logic [AW-1:0]          rdPtr, wrPtr;
  logic [CW-1:0]          count;
  logic [OW-1:0]          outstanding, dropCnt;
  logic [TW-1:0]          tagRd, tagWr;

  logic [PC_WIDTH-1:0]    pcMem    [DEPTH];
  logic [INSTR_WIDTH-1:0] instrMem [DEPTH];
  logic [PC_WIDTH-1:0]    tagMem   [MAX_OUTSTANDING];

  logic memReq, grant, rsp, rspPush, pop, headValid;

  function automatic logic [TW-1:0] nextTag(input logic [TW-1:0] p);
    if (p == TW'(MAX_OUTSTANDING - 1)) return '0;
    return p + TW'(1);
  endfunction

  // Reserving a queue slot per outstanding request means a response can always be written.
  always_comb begin
    memReq    = rst_i && !bus.redirect_i
             && (outstanding < OW'(MAX_OUTSTANDING))
             && (({1'b0, count} + (CW+1)'(outstanding)) < (CW+1)'(DEPTH));
    grant     = memReq && bus.mem_gnt_i;
    rsp       = bus.mem_rvalid_i && (outstanding != '0);
    rspPush   = rsp && (dropCnt == '0) && !bus.redirect_i;
    headValid = (count != '0) && !bus.redirect_i;
    pop       = headValid && bus.ready_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetchPc     <= RESET_PC;
      rdPtr       <= '0;
      wrPtr       <= '0;
      count       <= '0;
      outstanding <= '0;
      dropCnt     <= '0;
      tagRd       <= '0;
      tagWr       <= '0;
    end else begin
      outstanding <= outstanding + OW'(grant) - OW'(rsp);
      if (bus.redirect_i) begin
        fetchPc <= {bus.redirect_pc_i[PC_WIDTH-1:2], 2'b00};
        rdPtr   <= '0;
        wrPtr   <= '0;
        count   <= '0;
        tagRd   <= '0;
        tagWr   <= '0;
        // Everything still in flight after this cycle's response belongs to the old path.
        dropCnt <= outstanding - OW'(rsp);
      end else begin
        if (grant) begin
          fetchPc <= fetchPc + PC_WIDTH'(4);
          tagWr   <= nextTag(tagWr);
        end
        if (rspPush) begin
          wrPtr <= wrPtr + AW'(1);
          tagRd <= nextTag(tagRd);
        end
        if (rsp && (dropCnt != '0)) dropCnt <= dropCnt - OW'(1);
        if (pop) rdPtr <= rdPtr + AW'(1);
        if (rspPush && !pop)      count <= count + CW'(1);
        else if (!rspPush && pop) count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (grant) tagMem[tagWr] <= fetchPc;
    if (rspPush) begin
      pcMem[wrPtr]    <= tagMem[tagRd];
      instrMem[wrPtr] <= bus.mem_rdata_i;
    end
  end

  assign bus.mem_req_o  = memReq;
  assign bus.mem_addr_o = fetchPc;
  assign bus.valid_o    = headValid;
  assign bus.instr_o    = headValid ? instrMem[rdPtr] : NOP;
  assign bus.pc_o       = headValid ? pcMem[rdPtr] : '0;
  assign bus.pc_plus4_o = headValid ? pcMem[rdPtr] + PC_WIDTH'(4) : '0;
  assign bus.count_o    = count;
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: a latency-variable memory responder drives the DUT and a
// queue-based reference model predicts every output on every cycle.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam int          MAXO     = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if #(.PC_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(DEPTH)) bus ();

  fetch_queue #(
    .PC_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RESET_PC)
  ) dut (
    .clk_i(clk),
    .rst_i(rstN),
    .bus  (bus)
  );

  int nCmp = 0;
  int nBad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC0DE_0001;
  endfunction

  // Reference model: decoded queue contents plus the list of in-flight fetches.
  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct packed { logic [31:0] pc; logic kill; } fl_t;
  ent_t mq[$];
  fl_t  mf[$];
  logic [31:0] mPc = RESET_PC;
  logic expReq, expValid;
  fl_t  fh;

  always @(negedge clk) begin
    if (!rstN) begin
      chk("rst_req",   32'(bus.mem_req_o),  32'd0);
      chk("rst_addr",  bus.mem_addr_o,      RESET_PC);
      chk("rst_valid", 32'(bus.valid_o),    32'd0);
      chk("rst_instr", bus.instr_o,         NOP);
      chk("rst_pc",    bus.pc_o,            32'd0);
      chk("rst_pc4",   bus.pc_plus4_o,      32'd0);
      chk("rst_count", 32'(bus.count_o),    32'd0);
      mq.delete();
      mf.delete();
      mPc = RESET_PC;
    end else begin
      expReq   = !bus.redirect_i && (mf.size() < MAXO) && (mq.size() + mf.size() < DEPTH);
      expValid = (mq.size() != 0) && !bus.redirect_i;
      chk("req",   32'(bus.mem_req_o), 32'(expReq));
      chk("addr",  bus.mem_addr_o,     mPc);
      chk("valid", 32'(bus.valid_o),   32'(expValid));
      chk("instr", bus.instr_o,        expValid ? mq[0].instr : NOP);
      chk("pc",    bus.pc_o,           expValid ? mq[0].pc : 32'd0);
      chk("pc4",   bus.pc_plus4_o,     expValid ? mq[0].pc + 32'd4 : 32'd0);
      chk("count", 32'(bus.count_o),   32'(mq.size()));
      if (bus.mem_rvalid_i && mf.size() > 0) begin
        fh = mf.pop_front();
        if (!fh.kill && !bus.redirect_i) mq.push_back('{fh.pc, bus.mem_rdata_i});
      end
      if (expValid && bus.ready_i) void'(mq.pop_front());
      if (expReq && bus.mem_gnt_i) begin
        mf.push_back('{mPc, 1'b0});
        mPc = mPc + 32'd4;
      end
      if (bus.redirect_i) begin
        mq.delete();
        foreach (mf[i]) mf[i].kill = 1'b1;
        mPc = {bus.redirect_pc_i[31:2], 2'b00};
      end
    end
  end

  // Memory responder and stimulus knobs.
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pend[$];
  int cyc = 0;
  bit holdRst = 1'b1;
  int gntPct = 100, rdyPct = 100, redirPm = 0, spurPct = 0, latMin = 1, latMax = 1;
  bit forceRedir = 1'b0;
  logic [31:0] redirTarget = '0;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    rstN = !holdRst;
    if (!rstN) pend.delete();
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = $urandom;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = instrOf(pend[0].addr);
      void'(pend.pop_front());
    end else if (pend.size() == 0 && $urandom_range(99) < spurPct) begin
      bus.mem_rvalid_i = 1'b1;
    end
    bus.mem_gnt_i     = ($urandom_range(99) < gntPct);
    bus.ready_i       = ($urandom_range(99) < rdyPct);
    bus.redirect_i    = forceRedir || ($urandom_range(999) < redirPm);
    bus.redirect_pc_i = forceRedir ? redirTarget : $urandom;
    #1;
    if (rstN && bus.mem_req_o && bus.mem_gnt_i)
      pend.push_back('{bus.mem_addr_o, cyc + int'($urandom_range(latMax, latMin))});
  endtask

  task automatic doReset();
    holdRst = 1'b1;
    rstN    = 1'b0;
    repeat (2) step();
    holdRst = 1'b0;
  endtask

  initial begin
    bus.redirect_i = 0; bus.redirect_pc_i = 0; bus.mem_gnt_i = 0;
    bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0; bus.ready_i = 0;
    repeat (3) step();
    chk("lit_rst_count", 32'(bus.count_o), 32'd0);
    chk("lit_rst_req",   32'(bus.mem_req_o), 32'd0);

    // Streaming: gnt=1, L=1, ready=1.
    holdRst = 1'b0;
    step();
    chk("s_req0",  32'(bus.mem_req_o), 32'd1);
    chk("s_addr0", bus.mem_addr_o, 32'h0);
    step();
    chk("s_addr1",  bus.mem_addr_o, 32'h4);
    chk("s_valid1", 32'(bus.valid_o), 32'd0);
    step();
    chk("s_valid2", 32'(bus.valid_o), 32'd1);
    chk("s_pc2",    bus.pc_o, 32'h0);
    chk("s_pc4_2",  bus.pc_plus4_o, 32'h4);
    chk("s_instr2", bus.instr_o, instrOf(32'h0));
    chk("s_addr2",  bus.mem_addr_o, 32'h8);
    step();
    chk("s_pc3", bus.pc_o, 32'h4);
    repeat (6) step();

    // Backpressure fills the queue, then drains in order.
    rdyPct = 0;
    doReset();
    repeat (6) step();
    chk("bp_count", 32'(bus.count_o), 32'd4);
    chk("bp_req",   32'(bus.mem_req_o), 32'd0);
    rdyPct = 100;
    step();
    chk("bp_pc0",  bus.pc_o, 32'h0);
    chk("bp_req6", 32'(bus.mem_req_o), 32'd0);
    step();
    chk("bp_pc1",  bus.pc_o, 32'h4);
    chk("bp_addr", bus.mem_addr_o, 32'h10);
    chk("bp_req7", 32'(bus.mem_req_o), 32'd1);

    // Redirect with the queue full while decode is ready.
    rdyPct = 0;
    repeat (6) step();
    chk("fr_full", 32'(bus.count_o), 32'd4);
    rdyPct = 100; forceRedir = 1'b1; redirTarget = 32'h200;
    step();
    chk("fr_valid", 32'(bus.valid_o), 32'd0);
    chk("fr_req",   32'(bus.mem_req_o), 32'd0);
    forceRedir = 1'b0;
    step();
    chk("fr_count", 32'(bus.count_o), 32'd0);
    chk("fr_addr",  bus.mem_addr_o, 32'h200);

    // Redirect while two fetches are in flight (L=3).
    latMin = 3; latMax = 3;
    doReset();
    repeat (2) step();
    step();
    chk("l3_req_sat", 32'(bus.mem_req_o), 32'd0);
    forceRedir = 1'b1; redirTarget = 32'h103;
    step();
    forceRedir = 1'b0;
    step();
    chk("l3_req",  32'(bus.mem_req_o), 32'd1);
    chk("l3_addr", bus.mem_addr_o, 32'h100);
    repeat (3) begin
      step();
      chk("l3_novalid", 32'(bus.valid_o), 32'd0);
    end
    step();
    chk("l3_valid", 32'(bus.valid_o), 32'd1);
    chk("l3_pc",    bus.pc_o, 32'h100);

    // Grant withheld, then a spurious response with nothing outstanding.
    latMin = 1; latMax = 1; gntPct = 0;
    doReset();
    repeat (5) begin
      step();
      chk("ng_addr", bus.mem_addr_o, 32'h0);
      chk("ng_cnt",  32'(bus.count_o), 32'd0);
    end
    spurPct = 100;
    step();
    spurPct = 0;
    step();
    chk("sp_count", 32'(bus.count_o), 32'd0);
    chk("sp_valid", 32'(bus.valid_o), 32'd0);
    gntPct = 100;
    repeat (4) step();

    // Address wrap at the top of the space.
    forceRedir = 1'b1; redirTarget = 32'hFFFF_FFFE;
    step();
    forceRedir = 1'b0;
    step();
    chk("wr_addr0", bus.mem_addr_o, 32'hFFFF_FFFC);
    step();
    chk("wr_addr1", bus.mem_addr_o, 32'h0);
    step();
    chk("wr_pc",  bus.pc_o, 32'hFFFF_FFFC);
    chk("wr_pc4", bus.pc_plus4_o, 32'h0);

    // Randomized traffic.
    gntPct = 70; rdyPct = 70; redirPm = 30; spurPct = 5; latMin = 1; latMax = 4;
    repeat (3000) step();

    // Asynchronous reset assertion mid-cycle.
    @(posedge clk);
    #3;
    holdRst = 1'b1;
    rstN = 1'b0;
    #1;
    chk("ar_req",   32'(bus.mem_req_o), 32'd0);
    chk("ar_valid", 32'(bus.valid_o), 32'd0);
    chk("ar_count", 32'(bus.count_o), 32'd0);
    chk("ar_addr",  bus.mem_addr_o, RESET_PC);
    repeat (2) step();
    holdRst = 1'b0;
    repeat (800) step();

    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
